router_out_arbiter: RTL and testbench

Wormhole output-port arbiter for the 5-port NoC router. It shares one AXI-Stream output port among `N_PORTS` input requesters using round-robin arbitration. A grant is held for a whole packet and released on the TLAST handshake. The block also keeps per-input packet counters that feed the router PMU. One instance sits in front of each router output, between the input queues and the link `out_mosi_o`/`out_miso_i`.

---
 rtl/router_out_arbiter.sv | 124 ++++++++++++
 tb/tb_router_out_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_out_arbiter.sv
// Wormhole round-robin arbiter sharing one AXI-Stream output among N_PORTS inputs.
// A grant is held for a whole packet, and each input keeps a saturating count of its completed packets.
//   state  | meaning
//   IDLE   | no owner; arbitrate among valid inputs starting after rr_ptr
//   BUSY   | owner in grant_q streams through until its TLAST handshake
module router_out_arbiter #(
  parameter int N_PORTS    = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [N_PORTS-1:0]    in_tvalid_i,
  input  logic [DATA_WIDTH-1:0] in_tdata_i [N_PORTS],
  input  logic [N_PORTS-1:0]    in_tlast_i,
  output logic [N_PORTS-1:0]    in_tready_o,
  output logic                  out_tvalid_o,
  output logic [DATA_WIDTH-1:0] out_tdata_o,
  output logic                  out_tlast_o,
  input  logic                  out_tready_i,
  output logic [N_PORTS-1:0]    grant_o,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_o [N_PORTS],
  input  logic                  cnt_clear_i
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                             state_q, state_d;
  logic [N_PORTS-1:0]                 grant_q, grant_d;
  logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [N_PORTS-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [PTR_W-1:0] owner_idx;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_vld;
  logic             release_hs;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= PTR_W'(N_PORTS - 1);
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_q[i]) owner_idx = PTR_W'(i);
    end
  end

  // Search starts one past the last owner so every requester gets a turn.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      int idx;
      idx = (int'(rr_ptr_q) + i) % N_PORTS;
      if (!pick_vld && in_tvalid_i[idx]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          rr_ptr_d          = pick_idx;
          state_d           = S_BUSY;
        end
      end
      S_BUSY: begin
        if (release_hs) begin
          grant_d = '0;
          state_d = S_IDLE;
          if (cnt_q[owner_idx] != '1) cnt_d[owner_idx] = cnt_q[owner_idx] + CNT_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (cnt_clear_i) cnt_d = '0;
  end

  // Gating with rst_n_i keeps a beat from completing in the cycle reset is sampled.
  always_comb begin
    out_tvalid_o = 1'b0;
    out_tdata_o  = '0;
    out_tlast_o  = 1'b0;
    in_tready_o  = '0;
    if (state_q == S_BUSY && rst_n_i) begin
      out_tvalid_o           = in_tvalid_i[owner_idx];
      out_tdata_o            = in_tdata_i[owner_idx];
      out_tlast_o            = in_tlast_i[owner_idx];
      in_tready_o[owner_idx] = out_tready_i;
    end
    release_hs = out_tvalid_o && out_tready_i && out_tlast_o;
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == S_BUSY);

  for (genvar g = 0; g < N_PORTS; g++) begin : g_cnt_out
    assign pkt_cnt_o[g] = cnt_q[g];
  end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: inputs change 1 time unit after each rising edge,
// and every check is an immediate assertion against hand-computed values.
module tb_router_out_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [4:0]  in_tvalid;
  logic [31:0] in_tdata [5];
  logic [4:0]  in_tlast;
  logic [4:0]  in_tready;
  logic        out_tvalid;
  logic [31:0] out_tdata;
  logic        out_tlast;
  logic        out_tready;
  logic [4:0]  grant;
  logic        busy;
  logic [15:0] pkt_cnt [5];
  logic        cnt_clear;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int hs_start;
  logic [4:0][15:0] force_val;

  router_out_arbiter #(.N_PORTS(5), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_tvalid_i (in_tvalid),
    .in_tdata_i  (in_tdata),
    .in_tlast_i  (in_tlast),
    .in_tready_o (in_tready),
    .out_tvalid_o(out_tvalid),
    .out_tdata_o (out_tdata),
    .out_tlast_o (out_tlast),
    .out_tready_i(out_tready),
    .grant_o     (grant),
    .busy_o      (busy),
    .pkt_cnt_o   (pkt_cnt),
    .cnt_clear_i (cnt_clear)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (out_tvalid && out_tready) hs_cnt++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n_i    = 1'b0;
    in_tvalid  = '0;
    in_tlast   = '0;
    out_tready = 1'b1;
    cnt_clear  = 1'b0;
    for (int i = 0; i < 5; i++) in_tdata[i] = '0;
    tick();
    tick();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_out_tvalid", 64'(out_tvalid), 64'h0);
    chk("rst_out_tdata", 64'(out_tdata), 64'h0);
    chk("rst_in_tready", 64'(in_tready), 64'h0);
    for (int i = 0; i < 5; i++) chk($sformatf("rst_cnt%0d", i), 64'(pkt_cnt[i]), 64'h0);
    rst_n_i = 1'b1;

    // single 3-beat packet from input 2
    in_tvalid   = 5'b00100;
    in_tdata[2] = 32'hA1;
    #1;
    chk("idle_out_tvalid", 64'(out_tvalid), 64'h0);
    chk("idle_in_tready", 64'(in_tready), 64'h0);
    tick();
    chk("p2_grant", 64'(grant), 64'h04);
    chk("p2_busy", 64'(busy), 64'h1);
    chk("p2_beat1", 64'(out_tdata), 64'hA1);
    chk("p2_tready", 64'(in_tready), 64'h04);
    tick();
    in_tdata[2] = 32'hA2;
    #1;
    chk("p2_beat2", 64'(out_tdata), 64'hA2);
    tick();
    in_tdata[2] = 32'hA3;
    in_tlast    = 5'b00100;
    #1;
    chk("p2_beat3", 64'(out_tdata), 64'hA3);
    chk("p2_tlast", 64'(out_tlast), 64'h1);
    tick();
    in_tvalid = '0;
    in_tlast  = '0;
    #1;
    chk("p2_busy_fall", 64'(busy), 64'h0);
    chk("p2_grant_clr", 64'(grant), 64'h0);
    chk("p2_cnt", 64'(pkt_cnt[2]), 64'h1);

    // all inputs request continuously, single-beat packets
    rst_n_i = 1'b0;
    tick();
    rst_n_i   = 1'b1;
    in_tvalid = 5'b11111;
    in_tlast  = 5'b11111;
    for (int i = 0; i < 5; i++) in_tdata[i] = 32'h10 + i;
    for (int p = 0; p < 6; p++) begin
      #1;
      chk($sformatf("rr_bubble%0d", p), 64'(busy), 64'h0);
      tick();
      chk($sformatf("rr_grant%0d", p), 64'(grant), 64'(5'b1 << (p % 5)));
      chk($sformatf("rr_data%0d", p), 64'(out_tdata), 64'(32'h10 + (p % 5)));
      tick();
      if (p == 4) begin
        for (int i = 0; i < 5; i++) chk($sformatf("rr_cnt%0d", i), 64'(pkt_cnt[i]), 64'h1);
      end
    end
    in_tvalid = '0;
    in_tlast  = '0;
    #1;
    chk("rr_cnt0_after6", 64'(pkt_cnt[0]), 64'h2);

    // lock: input 1 stalls mid-packet while input 3 requests
    in_tvalid   = 5'b00010;
    in_tdata[1] = 32'hB1;
    tick();
    chk("lock_grant1", 64'(grant), 64'h02);
    tick();
    in_tvalid   = 5'b01000;
    in_tdata[3] = 32'hC1;
    in_tlast    = 5'b01000;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("lock_hold%0d", c), 64'(grant), 64'h02);
      chk($sformatf("lock_tready%0d", c), 64'(in_tready), 64'h02);
      chk($sformatf("lock_tvalid%0d", c), 64'(out_tvalid), 64'h0);
      tick();
    end
    in_tvalid   = 5'b01010;
    in_tdata[1] = 32'hB2;
    in_tlast    = 5'b01010;
    #1;
    chk("lock_b2", 64'(out_tdata), 64'hB2);
    chk("lock_b2_tready", 64'(in_tready), 64'h02);
    tick();
    in_tvalid = 5'b01000;
    #1;
    chk("lock_release", 64'(grant), 64'h0);
    chk("lock_idle_tready", 64'(in_tready), 64'h0);
    tick();
    chk("lock_grant3", 64'(grant), 64'h08);
    chk("lock_c1", 64'(out_tdata), 64'hC1);
    tick();
    in_tvalid = '0;
    in_tlast  = '0;
    #1;
    chk("lock_cnt1", 64'(pkt_cnt[1]), 64'h2);
    chk("lock_cnt3", 64'(pkt_cnt[3]), 64'h2);

    // backpressure on beat 2 of a 4-beat packet from input 4
    hs_start    = hs_cnt;
    in_tvalid   = 5'b10000;
    in_tdata[4] = 32'hD1;
    tick();
    chk("bp_grant4", 64'(grant), 64'h10);
    chk("bp_d1", 64'(out_tdata), 64'hD1);
    tick();
    in_tdata[4] = 32'hD2;
    out_tready  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("bp_hold%0d", c), 64'(out_tdata), 64'hD2);
      chk($sformatf("bp_valid%0d", c), 64'(out_tvalid), 64'h1);
      chk($sformatf("bp_tready%0d", c), 64'(in_tready), 64'h0);
      tick();
    end
    out_tready = 1'b1;
    #1;
    chk("bp_tready_on", 64'(in_tready), 64'h10);
    tick();
    in_tdata[4] = 32'hD3;
    tick();
    in_tdata[4] = 32'hD4;
    in_tlast    = 5'b10000;
    tick();
    in_tvalid = '0;
    in_tlast  = '0;
    #1;
    chk("bp_beats", 64'(hs_cnt - hs_start), 64'd4);
    chk("bp_cnt4", 64'(pkt_cnt[4]), 64'h2);
    chk("bp_busy", 64'(busy), 64'h0);

    // counter saturation on input 0
    force_val = {16'd2, 16'd2, 16'd1, 16'd2, 16'hFFFF};
    force dut.cnt_q = force_val;
    #1;
    release dut.cnt_q;
    #1;
    chk("sat_preset", 64'(pkt_cnt[0]), 64'hFFFF);
    in_tvalid   = 5'b00001;
    in_tlast    = 5'b00001;
    in_tdata[0] = 32'h55;
    tick();
    chk("sat_grant0", 64'(grant), 64'h01);
    tick();
    in_tvalid = '0;
    in_tlast  = '0;
    #1;
    chk("sat_hold", 64'(pkt_cnt[0]), 64'hFFFF);

    // clear wins over a same-cycle increment
    in_tvalid   = 5'b00100;
    in_tlast    = 5'b00100;
    in_tdata[2] = 32'hE1;
    tick();
    chk("clr_grant2", 64'(grant), 64'h04);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    in_tvalid = '0;
    in_tlast  = '0;
    #1;
    for (int i = 0; i < 5; i++) chk($sformatf("clr_cnt%0d", i), 64'(pkt_cnt[i]), 64'h0);

    // reset during beat 2 of a packet from input 1
    in_tvalid   = 5'b00010;
    in_tdata[1] = 32'hF1;
    tick();
    chk("mr_grant1", 64'(grant), 64'h02);
    tick();
    in_tdata[1] = 32'hF2;
    rst_n_i     = 1'b0;
    #1;
    chk("mr_no_beat", 64'(out_tvalid), 64'h0);
    chk("mr_no_tready", 64'(in_tready), 64'h0);
    tick();
    chk("mr_tvalid", 64'(out_tvalid), 64'h0);
    chk("mr_grant", 64'(grant), 64'h0);
    chk("mr_busy", 64'(busy), 64'h0);
    rst_n_i     = 1'b1;
    in_tvalid   = 5'b10001;
    in_tlast    = 5'b10001;
    in_tdata[0] = 32'h70;
    in_tdata[4] = 32'h74;
    tick();
    chk("mr_regrant0", 64'(grant), 64'h01);
    chk("mr_data0", 64'(out_tdata), 64'h70);
    tick();
    in_tvalid = '0;
    in_tlast  = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
